cci_mpf_mmio_initiator: RTL and testbench
=========================================

// Module: cci_mpf_mmio_initiator
//
// PURPOSE
// - MMIO initiator: drives CSR read/write requests into a CSR responder's c0Rx-style MMIO inputs and collects c2Tx-style read responses.
// - Used as the host-side emulator in MPF CSR shim benches and in on-FPGA self-test harnesses.
// - Allocates read TIDs, tracks outstanding reads, and matches out-of-order responses by TID.
// - Flags timeouts and unexpected TIDs.
//
// PARAMETERS
// - MMIO_ADDR_BITS   16    MMIO address width, 4-byte units (low 2 byte bits not carried)
// - TID_BITS         9     CCI-P MMIO TID width
// - MAX_OUTSTANDING  64    read tracking slots; power of 2, <= 2**TID_BITS
// - TIMEOUT_CYCLES   4096  no-progress limit while reads are outstanding; >= 2
//
// PORTS
// - clk             in   1               clock
// - reset           in   1               asynchronous reset, active-high
// - cmd_valid       in   1               command offered
// - cmd_ready       out  1               command accepted when cmd_valid && cmd_ready
// - cmd_write       in   1               1 = CSR write, 0 = CSR read
// - cmd_addr        in   MMIO_ADDR_BITS  target CSR address (4-byte units)
// - cmd_data        in   64              write data; ignored for reads
// - mmio_rd_valid   out  1               MMIO read request pulse, toward responder
// - mmio_wr_valid   out  1               MMIO write request pulse, toward responder
// - mmio_addr       out  MMIO_ADDR_BITS  request address
// - mmio_tid        out  TID_BITS        request TID
// - mmio_data       out  64              write data; 0 on reads
// - rsp_valid       in   1               responder mmioRdValid
// - rsp_tid         in   TID_BITS        response TID
// - rsp_data        in   64              response data
// - rd_done_valid   out  1               completed-read pulse
// - rd_done_addr    out  MMIO_ADDR_BITS  address of the completed read
// - rd_done_data    out  64              data of the completed read
// - outstanding     out  $clog2(MAX_OUTSTANDING)+1  count of reads in flight
// - err_timeout     out  1               sticky timeout flag
// - err_bad_tid     out  1               sticky unexpected-TID flag
//
// BEHAVIOUR
// - Reset (async assert, sync deassert usage):
//   - All outputs go to 0; all slots are freed; alloc pointer = 0; timer = 0.
// - Tracking table:
//   - MAX_OUTSTANDING entries of {busy, addr}.
//   - alloc_ptr advances modulo MAX_OUTSTANDING on each accepted read.
// - cmd_ready:
//   - Equals !busy[alloc_ptr], using registered state only.
//   - Applies to writes too, so the command stream stays in order.
//   - A slot freed this cycle raises cmd_ready next cycle.
// - Accepted command (1-cycle latency):
//   - Next cycle, exactly one of mmio_rd_valid / mmio_wr_valid is high for 1 cycle, with addr/data registered.
//   - Reads: mmio_tid = alloc_ptr zero-extended; busy[alloc_ptr] <= 1; addr stored.
//   - Writes: mmio_tid = 0; no slot is consumed; the pointer does not move.
//   - At most 1 request per cycle. Back-to-back issue is allowed.
// - Response handling:
//   - rsp_valid with rsp_tid < MAX_OUTSTANDING and busy[rsp_tid]:
//     - clear busy;
//     - next cycle pulse rd_done_valid with stored addr and rsp_data.
//   - Any other rsp_valid sets err_bad_tid: no done pulse, no state change.
//   - Responses may arrive in any order; one per cycle.
// - outstanding:
//   - +1 on read issue, -1 on valid retire; simultaneous issue and retire leave it unchanged.
//   - Never wraps: issue is impossible when all slots are busy.
// - Timer:
//   - Counts while outstanding != 0.
//   - Clears on any valid retire, and whenever outstanding == 0.
//   - Reaching TIMEOUT_CYCLES sets err_timeout.
//   - Saturates; no slot is freed.
// - Error flags are sticky and cleared only by reset.
// - Reset mid-operation:
//   - Outstanding reads are dropped.
//   - Later responses for them set err_bad_tid.
//
// TESTING
// - Read addr 0x0010 after reset -> next cycle mmio_rd_valid=1, tid=0, addr=0x0010; rsp tid 0 data 0xDEAD -> rd_done addr=0x0010 data=0xDEAD, outstanding 1->0.
// - Write addr 0x0004 data 0x1234, then a read -> wr pulse tid=0 data=0x1234; the read gets tid=0 (writes do not consume slots).
// - Issue 64 reads back-to-back -> tids 0..63, cmd_ready low at 64; retire tid 0 -> cmd_ready high next cycle; next read gets tid 0.
// - Reads tid 0,1,2 answered 2,0,1 -> three done pulses carrying each read's own address, in response order.
// - Response tid 5 with nothing outstanding, or tid 70 -> err_bad_tid=1, no rd_done_valid.
// - One read never answered -> err_timeout=1 exactly TIMEOUT_CYCLES cycles after issue; a response that arrives before then keeps it 0.

Source files
------------

// File: rtl/cci_mpf_mmio_initiator.sv
// Host-side MMIO initiator: issues CSR reads/writes toward a CSR responder,
// tracks outstanding reads by TID and flags timeouts and unexpected responses.
module cci_mpf_mmio_initiator #(
  parameter int MMIO_ADDR_BITS  = 16,
  parameter int TID_BITS        = 9,
  parameter int MAX_OUTSTANDING = 64,
  parameter int TIMEOUT_CYCLES  = 4096
) (
  input  logic                          clk,
  input  logic                          reset,

  input  logic                          cmd_valid,
  output logic                          cmd_ready,
  input  logic                          cmd_write,
  input  logic [MMIO_ADDR_BITS-1:0]     cmd_addr,
  input  logic [63:0]                   cmd_data,

  output logic                          mmio_rd_valid,
  output logic                          mmio_wr_valid,
  output logic [MMIO_ADDR_BITS-1:0]     mmio_addr,
  output logic [TID_BITS-1:0]           mmio_tid,
  output logic [63:0]                   mmio_data,

  input  logic                          rsp_valid,
  input  logic [TID_BITS-1:0]           rsp_tid,
  input  logic [63:0]                   rsp_data,

  output logic                          rd_done_valid,
  output logic [MMIO_ADDR_BITS-1:0]     rd_done_addr,
  output logic [63:0]                   rd_done_data,

  output logic [$clog2(MAX_OUTSTANDING):0] outstanding,
  output logic                          err_timeout,
  output logic                          err_bad_tid
);

  localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int CNT_W = $clog2(MAX_OUTSTANDING) + 1;
  localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [MAX_OUTSTANDING-1:0] busy;
  logic [MMIO_ADDR_BITS-1:0]  addr_tbl [MAX_OUTSTANDING];
  logic [PTR_W-1:0]           alloc_ptr;
  logic [TMR_W-1:0]           timer;
  logic [TMR_W-1:0]           timer_nxt;

  logic             accept;
  logic             accept_rd;
  logic             tid_in_range;
  logic [PTR_W-1:0] rsp_idx;
  logic             rsp_hit;

  // Ready is held low during reset so every output reads 0 while it is asserted.
  assign cmd_ready    = !reset && !busy[alloc_ptr];
  assign accept       = cmd_valid && cmd_ready;
  assign accept_rd    = accept && !cmd_write;
  assign tid_in_range = ({1'b0, rsp_tid} < (TID_BITS + 1)'(MAX_OUTSTANDING));
  assign rsp_idx      = rsp_tid[PTR_W-1:0];
  assign rsp_hit      = rsp_valid && tid_in_range && busy[rsp_idx];

  // An issue and a retire can never target the same slot: issue needs the
  // slot free, retire needs it busy.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy      <= '0;
      alloc_ptr <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every process
      // sees the pre-edge values regardless of evaluation order.
      if (accept_rd) begin
        busy[alloc_ptr] <= 1'b1;
        alloc_ptr       <= (alloc_ptr == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : alloc_ptr + PTR_W'(1);
      end
      if (rsp_hit) busy[rsp_idx] <= 1'b0;
    end
  end

  // NOTE: the address table is qualified by busy, so it needs no reset and
  // can map onto plain RAM.
  always_ff @(posedge clk) begin
    if (accept_rd) addr_tbl[alloc_ptr] <= cmd_addr;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mmio_rd_valid <= 1'b0;
      mmio_wr_valid <= 1'b0;
      mmio_addr     <= '0;
      mmio_tid      <= '0;
      mmio_data     <= '0;
    end else begin
      mmio_rd_valid <= accept_rd;
      mmio_wr_valid <= accept && cmd_write;
      if (accept) begin
        mmio_addr <= cmd_addr;
        mmio_tid  <= cmd_write ? '0 : TID_BITS'(alloc_ptr);
        mmio_data <= cmd_write ? cmd_data : 64'd0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_done_valid <= 1'b0;
      rd_done_addr  <= '0;
      rd_done_data  <= '0;
      err_bad_tid   <= 1'b0;
    end else begin
      rd_done_valid <= rsp_hit;
      if (rsp_hit) begin
        rd_done_addr <= addr_tbl[rsp_idx];
        rd_done_data <= rsp_data;
      end
      if (rsp_valid && !rsp_hit) err_bad_tid <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      outstanding <= '0;
    end else begin
      case ({accept_rd, rsp_hit})
        2'b10:   outstanding <= outstanding + CNT_W'(1);
        2'b01:   outstanding <= outstanding - CNT_W'(1);
        default: outstanding <= outstanding;
      endcase
    end
  end

  // Timer measures cycles without progress while reads are in flight.
  always_comb begin
    // NOTE: a default first keeps this combinational block latch-free.
    timer_nxt = timer;
    if (rsp_hit || outstanding == '0)
      timer_nxt = '0;
    else if (timer != TMR_W'(TIMEOUT_CYCLES))
      timer_nxt = timer + TMR_W'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      timer       <= '0;
      err_timeout <= 1'b0;
    end else begin
      timer <= timer_nxt;
      if (timer_nxt == TMR_W'(TIMEOUT_CYCLES)) err_timeout <= 1'b1;
    end
  end

endmodule

// File: tb/tb_cci_mpf_mmio_initiator.sv
// Self-checking bench for cci_mpf_mmio_initiator: directed scenarios plus
// random traffic compared against a transaction-level model.
module tb_cci_mpf_mmio_initiator;

  localparam int AW = 16;
  localparam int TW = 9;
  localparam int MO = 64;
  localparam int TO = 200;

  logic          clk = 1'b0;
  logic          reset;
  logic          cmd_valid, cmd_ready, cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [63:0]   cmd_data;
  logic          mmio_rd_valid, mmio_wr_valid;
  logic [AW-1:0] mmio_addr;
  logic [TW-1:0] mmio_tid;
  logic [63:0]   mmio_data;
  logic          rsp_valid;
  logic [TW-1:0] rsp_tid;
  logic [63:0]   rsp_data;
  logic          rd_done_valid;
  logic [AW-1:0] rd_done_addr;
  logic [63:0]   rd_done_data;
  logic [6:0]    outstanding;
  logic          err_timeout, err_bad_tid;

  cci_mpf_mmio_initiator #(
    .MMIO_ADDR_BITS(AW), .TID_BITS(TW), .MAX_OUTSTANDING(MO), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_data(cmd_data),
    .mmio_rd_valid(mmio_rd_valid), .mmio_wr_valid(mmio_wr_valid),
    .mmio_addr(mmio_addr), .mmio_tid(mmio_tid), .mmio_data(mmio_data),
    .rsp_valid(rsp_valid), .rsp_tid(rsp_tid), .rsp_data(rsp_data),
    .rd_done_valid(rd_done_valid), .rd_done_addr(rd_done_addr), .rd_done_data(rd_done_data),
    .outstanding(outstanding), .err_timeout(err_timeout), .err_bad_tid(err_bad_tid)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Model: set of pending reads keyed by TID, next TID, elapsed-time bookkeeping.
  logic [AW-1:0] pend [int];
  int  alloc;
  int  cyc;
  int  last_clear;
  bit  exp_to, exp_bt;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_data = '0;
    rsp_valid = 1'b0; rsp_tid = '0; rsp_data = '0;
    reset = 1'b1;
    #2;
    chk("rst_cmd_ready", cmd_ready, 0);
    chk("rst_rd_valid", mmio_rd_valid, 0);
    chk("rst_wr_valid", mmio_wr_valid, 0);
    chk("rst_mmio_addr", mmio_addr, 0);
    chk("rst_mmio_tid", mmio_tid, 0);
    chk("rst_mmio_data", mmio_data, 0);
    chk("rst_done_valid", rd_done_valid, 0);
    chk("rst_done_addr", rd_done_addr, 0);
    chk("rst_done_data", rd_done_data, 0);
    chk("rst_outstanding", outstanding, 0);
    chk("rst_err_timeout", err_timeout, 0);
    chk("rst_err_bad_tid", err_bad_tid, 0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    pend.delete();
    alloc = 0; exp_to = 0; exp_bt = 0; last_clear = cyc;
    #1;
    chk("post_rst_cmd_ready", cmd_ready, 1);
  endtask

  // One clock: drive inputs, advance model across the edge, check outputs #1 later.
  task automatic step(input bit cv, input bit cw, input logic [AW-1:0] ca, input logic [63:0] cd,
                      input bit rv, input logic [TW-1:0] rt, input logic [63:0] rdat);
    bit            acc, hit;
    int            tid;
    logic [AW-1:0] done_addr;
    acc = cv && !pend.exists(alloc);
    hit = rv && pend.exists(int'(rt));
    done_addr = '0;
    cmd_valid = cv; cmd_write = cw; cmd_addr = ca; cmd_data = cd;
    rsp_valid = rv; rsp_tid = rt; rsp_data = rdat;
    @(posedge clk);
    cyc++;
    if (pend.num() == 0 || hit) last_clear = cyc;
    if (hit) begin
      done_addr = pend[int'(rt)];
      pend.delete(int'(rt));
    end else if (rv) begin
      exp_bt = 1;
    end
    tid = alloc;
    if (acc && !cw) begin
      pend[alloc] = ca;
      alloc = (alloc + 1) % MO;
    end
    if (cyc - last_clear >= TO) exp_to = 1;
    #1;
    chk("cmd_ready", cmd_ready, !pend.exists(alloc));
    chk("mmio_rd_valid", mmio_rd_valid, acc && !cw);
    chk("mmio_wr_valid", mmio_wr_valid, acc && cw);
    if (acc) begin
      chk("mmio_addr", mmio_addr, ca);
      chk("mmio_tid", mmio_tid, cw ? 0 : tid);
      chk("mmio_data", mmio_data, cw ? cd : 64'd0);
    end
    chk("rd_done_valid", rd_done_valid, hit);
    if (hit) begin
      chk("rd_done_addr", rd_done_addr, done_addr);
      chk("rd_done_data", rd_done_data, rdat);
    end
    chk("outstanding", outstanding, pend.num());
    chk("err_timeout", err_timeout, exp_to);
    chk("err_bad_tid", err_bad_tid, exp_bt);
    cmd_valid = 1'b0;
    rsp_valid = 1'b0;
  endtask

  task automatic rd(input logic [AW-1:0] a);
    step(1, 0, a, 64'd0, 0, '0, 64'd0);
  endtask

  task automatic rsp(input logic [TW-1:0] t, input logic [63:0] d);
    step(0, 0, '0, 64'd0, 1, t, d);
  endtask

  task automatic idle();
    step(0, 0, '0, 64'd0, 0, '0, 64'd0);
  endtask

  initial begin
    cyc = 0;
    do_reset();

    // Single read round trip.
    rd(16'h0010);
    chk("first_tid", mmio_tid, 0);
    rsp(9'd0, 64'hDEAD);
    chk("first_done_data", rd_done_data, 64'hDEAD);
    idle();

    // Writes do not consume a TID.
    do_reset();
    step(1, 1, 16'h0004, 64'h1234, 0, '0, 64'd0);
    chk("wr_data", mmio_data, 64'h1234);
    rd(16'h0020);
    chk("rd_after_wr_tid", mmio_tid, 0);
    rsp(9'd0, 64'h55);

    // Fill all slots, then free one.
    do_reset();
    for (int i = 0; i < MO; i++) rd(AW'(16'h0100 + i));
    chk("full_ready_low", cmd_ready, 0);
    chk("full_outstanding", outstanding, MO);
    step(1, 0, 16'h0200, 64'd0, 0, '0, 64'd0);
    step(1, 0, 16'h0200, 64'd0, 1, 9'd0, 64'hA0);
    chk("freed_ready_high", cmd_ready, 1);
    rd(16'h0300);
    chk("reuse_tid0", mmio_tid, 0);
    for (int i = 1; i <= MO; i++) rsp(TW'(i % MO), 64'(i) << 8);

    // Out-of-order responses.
    do_reset();
    rd(16'h0A00); rd(16'h0B00); rd(16'h0C00);
    rsp(9'd2, 64'h22);
    chk("ooo_addr2", rd_done_addr, 16'h0C00);
    rsp(9'd0, 64'h00);
    chk("ooo_addr0", rd_done_addr, 16'h0A00);
    rsp(9'd1, 64'h11);
    chk("ooo_addr1", rd_done_addr, 16'h0B00);

    // Unexpected TIDs.
    do_reset();
    rsp(9'd5, 64'h5);
    chk("bad_tid5", err_bad_tid, 1);
    do_reset();
    rsp(9'd70, 64'h70);
    chk("bad_tid70", err_bad_tid, 1);
    idle();

    // Random traffic.
    do_reset();
    for (int n = 0; n < 600; n++) begin
      bit            cv, cw, rv;
      logic [TW-1:0] rt;
      cv = ($urandom_range(0, 2) != 0);
      cw = ($urandom_range(0, 3) == 0);
      rv = 0; rt = '0;
      if (pend.num() > 0 && $urandom_range(0, 2) != 0) begin
        int k, key;
        k = $urandom_range(0, pend.num() - 1);
        void'(pend.first(key));
        repeat (k) void'(pend.next(key));
        rv = 1; rt = key[TW-1:0];
      end else if ($urandom_range(0, 15) == 0) begin
        rv = 1; rt = TW'($urandom_range(0, 511));
      end
      step(cv, cw, AW'($urandom), {$urandom, $urandom}, rv, rt, {$urandom, $urandom});
    end

    // Response just before the limit keeps the timeout clear.
    do_reset();
    rd(16'h0040);
    repeat (TO - 2) idle();
    rsp(9'd0, 64'h77);
    repeat (4) idle();
    chk("no_timeout", err_timeout, 0);

    // Unanswered read times out exactly TO cycles after issue.
    do_reset();
    rd(16'h0044);
    repeat (TO - 1) idle();
    chk("timeout_not_yet", err_timeout, 0);
    idle();
    chk("timeout_set", err_timeout, 1);
    repeat (3) idle();

    // Reset drops the read; its late response is unexpected.
    do_reset();
    rsp(9'd0, 64'h99);
    chk("late_rsp_bad_tid", err_bad_tid, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
